// File: rtl/knn_pkg.sv
// Shared constants, FSM state type and per-feature helper for the k-nearest-neighbour block.
package knn_pkg;

    localparam int FEAT_W = 8;
    localparam int NFEAT = 4;
    localparam int DIST_W = 10;
    localparam logic [DIST_W-1:0] DIST_EMPTY = 10'h3FF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } knn_state_e;

    function automatic logic [FEAT_W-1:0] abs_diff(
        input logic [FEAT_W-1:0] a,
        input logic [FEAT_W-1:0] b
    );
        logic [FEAT_W-1:0] r;
        if (a >= b) begin
            r = a - b;
        end else begin
            r = b - a;
        end
        return r;
    endfunction

endpackage

// File: rtl/knn_l1_dist.sv
// Combinational L1 (Manhattan) distance between two packed feature vectors.
module knn_l1_dist
    import knn_pkg::*;
(
    input  logic [NFEAT*FEAT_W-1:0] a_i,
    input  logic [NFEAT*FEAT_W-1:0] b_i,
    output logic [DIST_W-1:0]       dist_o
);

    logic [DIST_W-1:0] sum_s;

    // Four 8-bit absolute differences sum to at most 1020, so 10 bits never overflow
    always_comb begin
        sum_s = '0;
        for (int f = 0; f < NFEAT; f++) begin
            sum_s = sum_s + DIST_W'(abs_diff(a_i[f*FEAT_W +: FEAT_W], b_i[f*FEAT_W +: FEAT_W]));
        end
    end

    assign dist_o = sum_s;

endmodule

// File: rtl/knn_dist_topk.sv
// Streams training samples against a latched query and keeps the K nearest (L1) in a sorted list.
module knn_dist_topk
    import knn_pkg::*;
#(
    parameter int K       = 4,
    parameter int LABEL_W = 4
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,
    input  logic                      query_valid,
    input  logic [31:0]               query_data,
    output logic                      query_ready,
    input  logic                      s_valid,
    input  logic [31:0]               s_data,
    input  logic [LABEL_W-1:0]        s_label,
    input  logic                      s_last,
    output logic                      s_ready,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [K*DIST_W-1:0]       res_dist,
    output logic [K*LABEL_W-1:0]      res_label,
    output logic [$clog2(K+1)-1:0]    res_count,
    output logic                      busy
);

    localparam int CNT_W = $clog2(K+1);

    knn_state_e state_q, state_d;

    logic [31:0]          query_q;
    logic                 query_ready_q, s_ready_q, res_valid_q, busy_q;

    logic                 st1_valid_q, st1_last_q;
    logic [DIST_W-1:0]    st1_dist_q;
    logic [LABEL_W-1:0]   st1_label_q;
    logic                 ins_last_q;

    logic [DIST_W-1:0]    list_dist_q  [K];
    logic [DIST_W-1:0]    list_dist_d  [K];
    logic [LABEL_W-1:0]   list_label_q [K];
    logic [LABEL_W-1:0]   list_label_d [K];
    logic [CNT_W-1:0]     count_q, count_d;

    logic [DIST_W-1:0]    sh_dist_s  [K];
    logic [LABEL_W-1:0]   sh_label_s [K];
    logic                 le_s       [K];
    logic                 prev_le_s  [K];

    logic                 q_hs_s, s_hs_s, r_hs_s;
    logic [DIST_W-1:0]    new_dist_s;

    assign q_hs_s = query_valid & query_ready_q;
    assign s_hs_s = s_valid & s_ready_q;
    assign r_hs_s = res_valid_q & res_ready;

    knn_l1_dist u_l1 (
        .a_i    (query_q),
        .b_i    (s_data),
        .dist_o (new_dist_s)
    );

    // Next-state logic for the query/stream/drain/result sequence
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (q_hs_s) state_d = STREAM;
                else        state_d = IDLE;
            end
            STREAM: begin
                if (s_hs_s && s_last) state_d = DRAIN;
                else                  state_d = STREAM;
            end
            DRAIN: begin
                if (ins_last_q) state_d = DONE;
                else            state_d = DRAIN;
            end
            DONE: begin
                if (r_hs_s) state_d = IDLE;
                else        state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register and handshake flags registered from the next state
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q       <= IDLE;
            query_ready_q <= 1'b1;
            s_ready_q     <= 1'b0;
            res_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            query_ready_q <= (state_d == IDLE);
            s_ready_q     <= (state_d == STREAM);
            res_valid_q   <= (state_d == DONE);
            busy_q        <= (state_d != IDLE);
        end
    end

    // Query latch and stage-1 pipeline (distance, label, last)
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            query_q     <= 32'h0000_0000;
            st1_valid_q <= 1'b0;
            st1_last_q  <= 1'b0;
            st1_dist_q  <= '0;
            st1_label_q <= '0;
            ins_last_q  <= 1'b0;
        end else begin
            if (q_hs_s) begin
                query_q <= query_data;
            end else begin
                query_q <= query_q;
            end
            st1_valid_q <= s_hs_s;
            st1_last_q  <= s_hs_s & s_last;
            if (s_hs_s) begin
                st1_dist_q  <= new_dist_s;
                st1_label_q <= s_label;
            end else begin
                st1_dist_q  <= st1_dist_q;
                st1_label_q <= st1_label_q;
            end
            ins_last_q <= st1_valid_q & st1_last_q;
        end
    end

    // Entry i keeps its value while it is <= the new distance; '<=' keeps ties in arrival order
    always_comb begin
        sh_dist_s[0]  = DIST_EMPTY;
        sh_label_s[0] = '0;
        prev_le_s[0]  = 1'b1;
        for (int i = 0; i < K; i++) begin
            le_s[i] = (list_dist_q[i] <= st1_dist_q);
        end
        for (int i = 1; i < K; i++) begin
            sh_dist_s[i]  = list_dist_q[i-1];
            sh_label_s[i] = list_label_q[i-1];
            prev_le_s[i]  = le_s[i-1];
        end
    end

    // Stage-2 sorted insertion, list clear on a new query
    always_comb begin
        list_dist_d  = list_dist_q;
        list_label_d = list_label_q;
        count_d      = count_q;
        if (q_hs_s) begin
            for (int i = 0; i < K; i++) begin
                list_dist_d[i]  = DIST_EMPTY;
                list_label_d[i] = '0;
            end
            count_d = '0;
        end else if (st1_valid_q) begin
            for (int i = 0; i < K; i++) begin
                if (le_s[i]) begin
                    list_dist_d[i]  = list_dist_q[i];
                    list_label_d[i] = list_label_q[i];
                end else if (prev_le_s[i]) begin
                    list_dist_d[i]  = st1_dist_q;
                    list_label_d[i] = st1_label_q;
                end else begin
                    list_dist_d[i]  = sh_dist_s[i];
                    list_label_d[i] = sh_label_s[i];
                end
            end
            if (count_q < CNT_W'(K)) begin
                count_d = count_q + CNT_W'(1);
            end else begin
                count_d = count_q;
            end
        end else begin
            count_d = count_q;
        end
    end

    // Sorted list and entry count registers
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int i = 0; i < K; i++) begin
                list_dist_q[i]  <= DIST_EMPTY;
                list_label_q[i] <= '0;
            end
            count_q <= '0;
        end else begin
            list_dist_q  <= list_dist_d;
            list_label_q <= list_label_d;
            count_q      <= count_d;
        end
    end

    // Pack the list onto the result buses, nearest entry in the LSBs
    always_comb begin
        res_dist  = '0;
        res_label = '0;
        for (int i = 0; i < K; i++) begin
            res_dist[i*DIST_W +: DIST_W]    = list_dist_q[i];
            res_label[i*LABEL_W +: LABEL_W] = list_label_q[i];
        end
    end

    assign query_ready = query_ready_q;
    assign s_ready     = s_ready_q;
    assign res_valid   = res_valid_q;
    assign busy        = busy_q;
    assign res_count   = count_q;

endmodule

// File: tb/tb_knn_dist_topk.sv
// Directed self-checking bench for knn_dist_topk with hand-computed neighbour lists.
module tb_knn_dist_topk;

    localparam int K  = 4;
    localparam int LW = 4;

    logic          ACLK        = 1'b0;
    logic          ARESETN     = 1'b0;
    logic          query_valid = 1'b0;
    logic [31:0]   query_data  = 32'h0;
    logic          query_ready;
    logic          s_valid     = 1'b0;
    logic [31:0]   s_data      = 32'h0;
    logic [LW-1:0] s_label     = 4'h0;
    logic          s_last      = 1'b0;
    logic          s_ready;
    logic          res_valid;
    logic          res_ready   = 1'b0;
    logic [K*10-1:0] res_dist;
    logic [K*LW-1:0] res_label;
    logic [2:0]      res_count;
    logic            busy;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0]   sd [16];
    logic [LW-1:0] sl [16];

    always #5 ACLK = ~ACLK;

    knn_dist_topk #(.K(K), .LABEL_W(LW)) dut (
        .ACLK        (ACLK),
        .ARESETN     (ARESETN),
        .query_valid (query_valid),
        .query_data  (query_data),
        .query_ready (query_ready),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_label     (s_label),
        .s_last      (s_last),
        .s_ready     (s_ready),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_dist    (res_dist),
        .res_label   (res_label),
        .res_count   (res_count),
        .busy        (busy)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [39:0] pk_d(input logic [9:0] a, input logic [9:0] b,
                                         input logic [9:0] c, input logic [9:0] d);
        return {d, c, b, a};
    endfunction

    function automatic logic [15:0] pk_l(input logic [3:0] a, input logic [3:0] b,
                                         input logic [3:0] c, input logic [3:0] d);
        return {d, c, b, a};
    endfunction

    task automatic run_query(input logic [31:0] q);
        int guard;
        guard = 0;
        while (!query_ready && guard < 20) begin
            @(posedge ACLK); #1;
            guard++;
        end
        if (!query_ready) check_val("query_ready_timeout", 64'd0, 64'd1);
        query_valid = 1'b1;
        query_data  = q;
        @(posedge ACLK); #1;
        query_valid = 1'b0;
    endtask

    task automatic send_set(input int n, input bit with_last, output int edges);
        edges = 0;
        for (int i = 0; i < n; i++) begin
            int guard;
            bit taken;
            s_valid = 1'b1;
            s_data  = sd[i];
            s_label = sl[i];
            s_last  = with_last && (i == n - 1);
            taken   = 1'b0;
            guard   = 0;
            while (!taken && guard < 20) begin
                taken = s_ready;
                @(posedge ACLK); #1;
                edges++;
                guard++;
            end
            if (!taken) check_val("s_accept_timeout", 64'd0, 64'd1);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        if (with_last) check_val("s_ready_drop", s_ready, 64'd0);
    endtask

    task automatic wait_done();
        int guard;
        guard = 0;
        while (!res_valid && guard < 40) begin
            @(posedge ACLK); #1;
            guard++;
        end
        if (!res_valid) check_val("res_valid_timeout", 64'd0, 64'd1);
    endtask

    task automatic check_result(input string tag, input logic [39:0] ed,
                                input logic [15:0] el, input logic [2:0] ec);
        check_val({tag, "_dist"},  res_dist,  ed);
        check_val({tag, "_label"}, res_label, el);
        check_val({tag, "_count"}, res_count, ec);
    endtask

    task automatic consume(input string tag);
        res_ready = 1'b1;
        @(posedge ACLK); #1;
        res_ready = 1'b0;
        check_val({tag, "_res_valid_off"}, res_valid, 64'd0);
        check_val({tag, "_query_ready"},   query_ready, 64'd1);
    endtask

    task automatic load_basic();
        sd[0] = 32'h10203040; sl[0] = 4'd1;
        sd[1] = 32'h00000000; sl[1] = 4'd2;
        sd[2] = 32'hFFFFFFFF; sl[2] = 4'd3;
        sd[3] = 32'h11213141; sl[3] = 4'd4;
        sd[4] = 32'h12223242; sl[4] = 4'd5;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int e;
        logic [39:0] empty_d;
        empty_d = pk_d(10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF);

        // Reset state
        repeat (3) @(posedge ACLK);
        #1;
        check_val("rst_query_ready", query_ready, 64'd1);
        check_val("rst_s_ready",     s_ready,     64'd0);
        check_val("rst_res_valid",   res_valid,   64'd0);
        check_val("rst_busy",        busy,        64'd0);
        check_result("rst", empty_d, 16'h0000, 3'd0);
        @(negedge ACLK);
        ARESETN = 1'b1;
        @(posedge ACLK); #1;

        // Basic set: distances 0,160,860,4,8
        load_basic();
        run_query(32'h10203040);
        check_val("basic_busy", busy, 64'd1);
        send_set(5, 1'b1, e);
        wait_done();
        check_result("basic", pk_d(10'd0, 10'd4, 10'd8, 10'd160), pk_l(4'd1, 4'd4, 4'd5, 4'd2), 3'd4);
        consume("basic");

        // Short set: one sample
        sd[0] = 32'h00000000; sl[0] = 4'd7;
        run_query(32'h10203040);
        send_set(1, 1'b1, e);
        wait_done();
        check_result("short", pk_d(10'd160, 10'h3FF, 10'h3FF, 10'h3FF), pk_l(4'd7, 4'd0, 4'd0, 4'd0), 3'd1);
        consume("short");

        // Tie: equal distance keeps arrival order
        sd[0] = 32'h00000001; sl[0] = 4'd1;
        sd[1] = 32'h01000000; sl[1] = 4'd2;
        run_query(32'h00000000);
        send_set(2, 1'b1, e);
        wait_done();
        check_result("tie", pk_d(10'd1, 10'd1, 10'h3FF, 10'h3FF), pk_l(4'd1, 4'd2, 4'd0, 4'd0), 3'd2);
        consume("tie");

        // Backpressure: hold res_ready low in DONE
        load_basic();
        run_query(32'h10203040);
        send_set(5, 1'b1, e);
        wait_done();
        for (int c = 0; c < 5; c++) begin
            check_val("bp_res_valid",   res_valid,   64'd1);
            check_val("bp_query_ready", query_ready, 64'd0);
            check_result("bp", pk_d(10'd0, 10'd4, 10'd8, 10'd160), pk_l(4'd1, 4'd4, 4'd5, 4'd2), 3'd4);
            @(posedge ACLK); #1;
        end
        consume("bp");

        // Reset after two samples of five
        load_basic();
        run_query(32'h10203040);
        send_set(2, 1'b0, e);
        ARESETN = 1'b0;
        #1;
        check_val("mid_rst_res_valid",   res_valid,   64'd0);
        check_val("mid_rst_query_ready", query_ready, 64'd1);
        check_val("mid_rst_busy",        busy,        64'd0);
        check_result("mid_rst", empty_d, 16'h0000, 3'd0);
        @(negedge ACLK);
        ARESETN = 1'b1;
        @(posedge ACLK); #1;
        run_query(32'h10203040);
        send_set(5, 1'b1, e);
        wait_done();
        check_result("rerun", pk_d(10'd0, 10'd4, 10'd8, 10'd160), pk_l(4'd1, 4'd4, 4'd5, 4'd2), 3'd4);
        consume("rerun");

        // Throughput: 16 back-to-back samples with distances 15 down to 0
        for (int k = 0; k < 16; k++) begin
            sd[k] = 32'(15 - k);
            sl[k] = 4'(15 - k);
        end
        run_query(32'h00000000);
        send_set(16, 1'b1, e);
        check_val("tput_edges", e, 64'd16);
        check_val("tput_res_valid_c0", res_valid, 64'd0);
        @(posedge ACLK); #1;
        check_val("tput_res_valid_c1", res_valid, 64'd0);
        @(posedge ACLK); #1;
        check_val("tput_res_valid_c2", res_valid, 64'd1);
        check_result("tput", pk_d(10'd0, 10'd1, 10'd2, 10'd3), pk_l(4'd0, 4'd1, 4'd2, 4'd3), 3'd4);
        consume("tput");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
